// File: rtl/icache_nb.sv
// icache_nb: non-blocking, direct-mapped instruction cache with 8-byte lines.
// Fetch looks up the line array combinationally. Misses issue line loads on a
// tagged memory bus. A small fill table tracks up to MAX_OUTSTANDING in-flight
// fills by memory tag, so several misses can be pending at once.
//
// Ports:
//   clock               system clock
//   reset               synchronous, active-low reset
//   proc2Icache_addr    fetch byte address (only bits [15:0] are significant)
//   Imem2proc_response  nonzero = load accepted this cycle, with this tag
//   Imem2proc_data      fill data, valid when Imem2proc_tag is nonzero
//   Imem2proc_tag       nonzero = data returning for this tag
//   proc2Imem_command   BUS_NONE=0 / BUS_LOAD=1
//   proc2Imem_addr      line address of the request, bits [2:0]=0
//   Icache_data_out     line data for proc2Icache_addr
//   Icache_valid_out    Icache_data_out is valid
//   outstanding_count   live fill-table entries
//
// Optional feature: define ICACHE_PREFETCH_EN to issue a next-line prefetch
// in cycles where no demand request goes out.
module icache_nb #(
    parameter int NUM_LINES       = 32,
    parameter int MAX_OUTSTANDING = 2,
    parameter int MEM_TAG_BITS    = 4
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic [63:0]                          proc2Icache_addr,
    input  logic [MEM_TAG_BITS-1:0]              Imem2proc_response,
    input  logic [63:0]                          Imem2proc_data,
    input  logic [MEM_TAG_BITS-1:0]              Imem2proc_tag,
    output logic [1:0]                           proc2Imem_command,
    output logic [63:0]                          proc2Imem_addr,
    output logic [63:0]                          Icache_data_out,
    output logic                                 Icache_valid_out,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_count
);
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int TAG_W  = 13 - IDX_W;
    localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int SLOT_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [1:0] BUS_NONE = 2'd0;
    localparam logic [1:0] BUS_LOAD = 2'd1;

    // Line array
    logic [NUM_LINES-1:0] line_valid;
    logic [TAG_W-1:0]     line_tag  [NUM_LINES];
    logic [63:0]          line_data [NUM_LINES];

    // Fill table
    logic [MAX_OUTSTANDING-1:0] ent_valid;
    logic [MEM_TAG_BITS-1:0]    ent_memtag [MAX_OUTSTANDING];
    logic [IDX_W-1:0]           ent_idx    [MAX_OUTSTANDING];
    logic [TAG_W-1:0]           ent_tag    [MAX_OUTSTANDING];

    logic [IDX_W-1:0]  cur_idx;
    logic [TAG_W-1:0]  cur_tag;
    logic              array_hit, cur_pending, have_free, fill_hit, bypass;
    logic [SLOT_W-1:0] free_slot, fill_slot;
    logic              req_valid, alloc;
    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic [63:0]       req_addr;
    logic              unused_addr_bits;
`ifdef ICACHE_PREFETCH_EN
    logic [12:0]       pf_line;
    logic [IDX_W-1:0]  pf_idx;
    logic [TAG_W-1:0]  pf_tag;
    logic              pf_hit, pf_pending;
`endif

    assign cur_idx          = proc2Icache_addr[3 +: IDX_W];
    assign cur_tag          = proc2Icache_addr[15 -: TAG_W];
    assign unused_addr_bits = ^proc2Icache_addr[2:0];

    always_comb begin
        array_hit   = line_valid[cur_idx] && (line_tag[cur_idx] == cur_tag);
        cur_pending = 1'b0;
        have_free   = 1'b0;
        free_slot   = '0;
        fill_hit    = 1'b0;
        fill_slot   = '0;
        // Free/fill status comes from registered state only, so a slot freed
        // by this cycle's fill is not handed out until next cycle.
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            if (ent_valid[i] && ent_idx[i] == cur_idx && ent_tag[i] == cur_tag)
                cur_pending = 1'b1;
            if (!ent_valid[i] && !have_free) begin
                have_free = 1'b1;
                free_slot = SLOT_W'(i);
            end
            if (ent_valid[i] && Imem2proc_tag != '0 &&
                ent_memtag[i] == Imem2proc_tag && !fill_hit) begin
                fill_hit  = 1'b1;
                fill_slot = SLOT_W'(i);
            end
        end
        bypass = fill_hit && ent_idx[fill_slot] == cur_idx &&
                 ent_tag[fill_slot] == cur_tag;

        req_valid = 1'b0;
        req_idx   = cur_idx;
        req_tag   = cur_tag;
        req_addr  = 64'd0;
`ifdef ICACHE_PREFETCH_EN
        pf_line    = proc2Icache_addr[15:3] + 13'd1;  // wraps within 16 bits
        pf_idx     = pf_line[IDX_W-1:0];
        pf_tag     = pf_line[12 -: TAG_W];
        pf_hit     = line_valid[pf_idx] && (line_tag[pf_idx] == pf_tag);
        pf_pending = 1'b0;
        for (int i = 0; i < MAX_OUTSTANDING; i++)
            if (ent_valid[i] && ent_idx[i] == pf_idx && ent_tag[i] == pf_tag)
                pf_pending = 1'b1;
`endif
        if (!array_hit && !cur_pending && have_free) begin
            req_valid = 1'b1;
            req_addr  = {proc2Icache_addr[63:3], 3'b000};
        end
`ifdef ICACHE_PREFETCH_EN
        else if (!pf_hit && !pf_pending && have_free) begin
            req_valid = 1'b1;
            req_idx   = pf_idx;
            req_tag   = pf_tag;
            req_addr  = {proc2Icache_addr[63:16], pf_line, 3'b000};
        end
`endif
    end

    assign alloc = reset && req_valid && (Imem2proc_response != '0);

    // While reset is held, every output is forced quiet.
    assign proc2Imem_command = (reset && req_valid) ? BUS_LOAD : BUS_NONE;
    assign proc2Imem_addr    = (reset && req_valid) ? req_addr : 64'd0;
    assign Icache_valid_out  = reset && (array_hit || bypass);
    assign Icache_data_out   = !reset ? 64'd0 :
                               bypass ? Imem2proc_data : line_data[cur_idx];

    // Control state: valid bits and the live-entry count
    always_ff @(posedge clock) begin
        if (!reset) begin
            line_valid        <= '0;
            ent_valid         <= '0;
            outstanding_count <= '0;
        end else begin
            if (fill_hit) begin
                line_valid[ent_idx[fill_slot]] <= 1'b1;
                ent_valid[fill_slot]           <= 1'b0;
            end
            if (alloc)
                ent_valid[free_slot] <= 1'b1;
            outstanding_count <= outstanding_count + CNT_W'(alloc) - CNT_W'(fill_hit);
        end
    end

    // Payload state: only meaningful where the matching valid bit is set
    always_ff @(posedge clock) begin
        if (fill_hit) begin
            line_tag[ent_idx[fill_slot]]  <= ent_tag[fill_slot];
            line_data[ent_idx[fill_slot]] <= Imem2proc_data;
        end
        if (alloc) begin
            ent_memtag[free_slot] <= Imem2proc_response;
            ent_idx[free_slot]    <= req_idx;
            ent_tag[free_slot]    <= req_tag;
        end
    end
endmodule

// File: tb/tb_icache_nb.sv
module tb_icache_nb;
    logic        clock;
    logic        reset;
    logic [63:0] proc2Icache_addr;
    logic [3:0]  Imem2proc_response;
    logic [63:0] Imem2proc_data;
    logic [3:0]  Imem2proc_tag;
    logic [1:0]  proc2Imem_command;
    logic [63:0] proc2Imem_addr;
    logic [63:0] Icache_data_out;
    logic        Icache_valid_out;
    logic [1:0]  outstanding_count;

    localparam logic [1:0] NONE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;

    icache_nb #(.NUM_LINES(32), .MAX_OUTSTANDING(2), .MEM_TAG_BITS(4)) dut (
        .clock(clock),
        .reset(reset),
        .proc2Icache_addr(proc2Icache_addr),
        .Imem2proc_response(Imem2proc_response),
        .Imem2proc_data(Imem2proc_data),
        .Imem2proc_tag(Imem2proc_tag),
        .proc2Imem_command(proc2Imem_command),
        .proc2Imem_addr(proc2Imem_addr),
        .Icache_data_out(Icache_data_out),
        .Icache_valid_out(Icache_valid_out),
        .outstanding_count(outstanding_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string       nm;
        logic [1:0]  cmd;
        logic [63:0] addr;
        logic        vld;
        logic        chk_data;
        logic [63:0] data;
        logic [1:0]  cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string nm, input string fld,
                         input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
        end
    endtask

    // Monitor: every falling edge, compare outputs against the oldest expectation
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check(e.nm, "cmd", 64'(proc2Imem_command), 64'(e.cmd));
            check(e.nm, "addr", proc2Imem_addr, e.addr);
            check(e.nm, "vld", 64'(Icache_valid_out), 64'(e.vld));
            check(e.nm, "cnt", 64'(outstanding_count), 64'(e.cnt));
            if (e.chk_data)
                check(e.nm, "data", Icache_data_out, e.data);
        end
    end

    // One cycle of stimulus plus the outputs expected during that cycle
    task automatic cyc(input string nm, input logic rst, input logic [63:0] a,
                       input logic [3:0] resp, input logic [3:0] ftag,
                       input logic [63:0] fdata, input logic [1:0] e_cmd,
                       input logic [63:0] e_addr, input logic e_vld,
                       input logic e_chkd, input logic [63:0] e_data,
                       input logic [1:0] e_cnt);
        exp_t e;
        @(posedge clock);
        #1;
        reset              = rst;
        proc2Icache_addr   = a;
        Imem2proc_response = resp;
        Imem2proc_tag      = ftag;
        Imem2proc_data     = fdata;
        e.nm = nm; e.cmd = e_cmd; e.addr = e_addr; e.vld = e_vld;
        e.chk_data = e_chkd; e.data = e_data; e.cnt = e_cnt;
        exp_q.push_back(e);
    endtask

    initial begin
        logic [1:0]  pf_cmd;
        logic [63:0] pf_addr;
`ifdef ICACHE_PREFETCH_EN
        pf_cmd = LOAD; pf_addr = 64'h108;
`else
        pf_cmd = NONE; pf_addr = 64'h0;
`endif
        reset = 1'b0; proc2Icache_addr = 64'h100;
        Imem2proc_response = 4'd0; Imem2proc_tag = 4'd0; Imem2proc_data = 64'd0;

        // reset, then a plain miss waiting for acceptance
        cyc("rst_a",   0, 64'h100, 0, 0, 0, NONE, 64'h0,   0, 1, 64'h0, 0);
        cyc("rst_b",   0, 64'h100, 0, 0, 0, NONE, 64'h0,   0, 1, 64'h0, 0);
        cyc("miss_a",  1, 64'h100, 0, 0, 0, LOAD, 64'h100, 0, 0, 64'h0, 0);
        cyc("miss_b",  1, 64'h100, 0, 0, 0, LOAD, 64'h100, 0, 0, 64'h0, 0);

        // accept with tag 3, fill 4 cycles later with bypass
        cyc("acc3",    1, 64'h100, 3, 0, 0, LOAD, 64'h100, 0, 0, 64'h0, 0);
        cyc("wait1",   1, 64'h100, 0, 0, 0, NONE, 64'h0,   0, 0, 64'h0, 1);
        cyc("wait2",   1, 64'h100, 0, 0, 0, NONE, 64'h0,   0, 0, 64'h0, 1);
        cyc("wait3",   1, 64'h100, 0, 0, 0, NONE, 64'h0,   0, 0, 64'h0, 1);
        cyc("bypass3", 1, 64'h100, 0, 3, 64'hDEADBEEF, NONE, 64'h0, 1, 1, 64'hDEADBEEF, 1);
        cyc("hit100",  1, 64'h100, 0, 0, 0, NONE, 64'h0,   1, 1, 64'hDEADBEEF, 0);

        // two outstanding, table full, out-of-order fills on a shared index
        cyc("rst2_a",  0, 64'h100, 0, 0, 0, NONE, 64'h0,   0, 1, 64'h0, 0);
        cyc("rst2_b",  0, 64'h100, 0, 0, 0, NONE, 64'h0,   0, 1, 64'h0, 0);
        cyc("m100r1",  1, 64'h100, 1, 0, 0, LOAD, 64'h100, 0, 0, 64'h0, 0);
        cyc("m200r2",  1, 64'h200, 2, 0, 0, LOAD, 64'h200, 0, 0, 64'h0, 1);
        cyc("full_a",  1, 64'h300, 5, 0, 0, NONE, 64'h0,   0, 0, 64'h0, 2);
        cyc("full_b",  1, 64'h300, 0, 0, 0, NONE, 64'h0,   0, 0, 64'h0, 2);
        cyc("fill2",   1, 64'h300, 0, 2, 64'h2222, NONE, 64'h0, 0, 0, 64'h0, 2);
        cyc("m300r4",  1, 64'h300, 4, 0, 0, LOAD, 64'h300, 0, 0, 64'h0, 1);
        cyc("hit200",  1, 64'h200, 0, 1, 64'h1111, NONE, 64'h0, 1, 1, 64'h2222, 2);
        cyc("hit100b", 1, 64'h100, 0, 0, 0, NONE, 64'h0,   1, 1, 64'h1111, 1);
        cyc("evict200",1, 64'h200, 0, 0, 0, LOAD, 64'h200, 0, 0, 64'h0, 1);
        cyc("byp4",    1, 64'h300, 0, 4, 64'h3333, NONE, 64'h0, 1, 1, 64'h3333, 1);
        cyc("hit300",  1, 64'h300, 0, 0, 0, NONE, 64'h0,   1, 1, 64'h3333, 0);

        // response withheld for 3 cycles, then one allocation only
        cyc("r0_a",    1, 64'h40, 0, 0, 0, LOAD, 64'h40,   0, 0, 64'h0, 0);
        cyc("r0_b",    1, 64'h40, 0, 0, 0, LOAD, 64'h40,   0, 0, 64'h0, 0);
        cyc("r0_c",    1, 64'h40, 0, 0, 0, LOAD, 64'h40,   0, 0, 64'h0, 0);
        cyc("r6",      1, 64'h40, 6, 0, 0, LOAD, 64'h40,   0, 0, 64'h0, 0);
        cyc("nodup",   1, 64'h40, 7, 0, 0, NONE, 64'h0,    0, 0, 64'h0, 1);
        cyc("hold40",  1, 64'h40, 0, 0, 0, NONE, 64'h0,    0, 0, 64'h0, 1);
        cyc("byp6",    1, 64'h40, 0, 6, 64'h4040, NONE, 64'h0, 1, 1, 64'h4040, 1);
        cyc("hit40",   1, 64'h40, 0, 0, 0, NONE, 64'h0,    1, 1, 64'h4040, 0);

        // reset with two live entries; stale fills afterwards are ignored
        cyc("m500r1",  1, 64'h500, 1, 0, 0, LOAD, 64'h500, 0, 0, 64'h0, 0);
        cyc("m600r2",  1, 64'h600, 2, 0, 0, LOAD, 64'h600, 0, 0, 64'h0, 1);
        cyc("live2",   1, 64'h600, 0, 0, 0, NONE, 64'h0,   0, 0, 64'h0, 2);
        cyc("rst3_a",  0, 64'h40,  0, 0, 0, NONE, 64'h0,   0, 1, 64'h0, 2);
        cyc("rst3_b",  0, 64'h40,  0, 0, 0, NONE, 64'h0,   0, 1, 64'h0, 0);
        cyc("stale1",  1, 64'h500, 0, 1, 64'hAAAA, LOAD, 64'h500, 0, 0, 64'h0, 0);
        cyc("stale2",  1, 64'h600, 0, 2, 64'hBBBB, LOAD, 64'h600, 0, 0, 64'h0, 0);
        cyc("after500",1, 64'h500, 0, 0, 0, LOAD, 64'h500, 0, 0, 64'h0, 0);
        cyc("after40", 1, 64'h40,  0, 0, 0, LOAD, 64'h40,  0, 0, 64'h0, 0);

        // next-line prefetch (only issued when the feature is built in)
        cyc("pf_m100", 1, 64'h100, 1, 0, 0, LOAD, 64'h100, 0, 0, 64'h0, 0);
        cyc("pf_byp",  1, 64'h100, 0, 1, 64'h5555, pf_cmd, pf_addr, 1, 1, 64'h5555, 1);
        cyc("pf_hit",  1, 64'h100, 0, 0, 0, pf_cmd, pf_addr, 1, 1, 64'h5555, 0);

        // let the monitor drain, bounded
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clock);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
